// File: rtl/wrr_arb_if.sv
// wrr_arb_if: request/config/grant bundle between requesters and the
// weighted round-robin arbiter. The lock signal exists only when the
// ARB_LOCK_EN macro is defined.
interface wrr_arb_if #(
   parameter int QW = 3
);
   logic [3:0]    req;
   logic          cfg_we;
   logic [1:0]    cfg_idx;
   logic [QW-1:0] cfg_q;
`ifdef ARB_LOCK_EN
   logic          lock;
`endif
   logic [3:0]    gnt;
   logic [1:0]    gnt_id;
   logic          busy;

`ifdef ARB_LOCK_EN
   modport master (output req, cfg_we, cfg_idx, cfg_q, lock,
                   input  gnt, gnt_id, busy);
   modport slave  (input  req, cfg_we, cfg_idx, cfg_q, lock,
                   output gnt, gnt_id, busy);
`else
   modport master (output req, cfg_we, cfg_idx, cfg_q,
                   input  gnt, gnt_id, busy);
   modport slave  (input  req, cfg_we, cfg_idx, cfg_q,
                   output gnt, gnt_id, busy);
`endif
endinterface

// File: rtl/wrr_arb.sv
// wrr_arb: four-requester weighted round-robin arbiter. Each requester owns a
// programmable quantum q and may hold the grant for up to q+1 cycles before
// the grant is handed to the next requester in round-robin order.
// Optional feature macro ARB_LOCK_EN: adds a lock input that suspends quantum
// expiry while the current owner keeps requesting.
module wrr_arb #(
   parameter int QW   = 3,
   parameter int NREQ = 4   // fixed at 4; the grant encoding assumes it
) (
   input logic      clk,
   input logic      rst,
   wrr_arb_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [QW-1:0] q_reg [NREQ];
   logic [QW-1:0] cnt, cnt_nxt;
   logic [QW-1:0] cur_q, cur_q_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [3:0]    gnt_r, gnt_nxt;
   logic [1:0]    id_r, id_nxt;
   logic          busy_r;
   logic [1:0]    sel;
   logic          hold;
   logic          expire;
   logic          start;

   // First requesting index when scanning p+1, p+2, p+3, p (mod 4).
   // Scanning downward lets the closest candidate overwrite the others.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] cand;
      logic [1:0] found;
      found = p;
      for (int k = 4; k >= 1; k--) begin
         cand = p + 2'(k);
         if (r[cand]) found = cand;
      end
      return found;
   endfunction

   assign bus.gnt    = gnt_r;
   assign bus.gnt_id = id_r;
   assign bus.busy   = busy_r;

   // Quantum table: written by the config port, restored to 3 on reset.
   // A write landing on the same edge as a new grant is not seen by that
   // grant because cur_q samples the table before this update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREQ; k++) q_reg[k] <= QW'(3);
      end else if (bus.cfg_we) begin
         q_reg[bus.cfg_idx] <= bus.cfg_q;
      end
   end

   // Next-state logic: while granted, ptr is the owner's index, so the same
   // search from ptr serves both the idle case and the release handover.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_q_nxt = cur_q;
      ptr_nxt   = ptr;
      gnt_nxt   = gnt_r;
      id_nxt    = id_r;
      start     = 1'b0;
      sel       = pick(bus.req, ptr);
`ifdef ARB_LOCK_EN
      hold      = bus.lock & bus.req[ptr];
`else
      hold      = 1'b0;
`endif
      expire    = (cnt == cur_q) & ~hold;

      case (state)
         IDLE: begin
            start = |bus.req;
         end
         GRANT: begin
            if (!bus.req[ptr] || expire) begin
               if (|bus.req) begin
                  start = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
                  id_nxt    = 2'd0;
               end
            end else if (cnt != cur_q) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            id_nxt    = 2'd0;
         end
      endcase

      if (start) begin
         state_nxt = GRANT;
         cnt_nxt   = '0;
         cur_q_nxt = q_reg[sel];
         ptr_nxt   = sel;
         gnt_nxt   = 4'b0001 << sel;
         id_nxt    = sel;
      end
   end

   // State and registered outputs; busy is derived from the same next grant
   // so all three outputs always agree within a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         cur_q  <= '0;
         ptr    <= 2'd3;
         gnt_r  <= 4'b0000;
         id_r   <= 2'd0;
         busy_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         cur_q  <= cur_q_nxt;
         ptr    <= ptr_nxt;
         gnt_r  <= gnt_nxt;
         id_r   <= id_nxt;
         busy_r <= |gnt_nxt;
      end
   end

endmodule

// File: tb/tb_wrr_arb.sv
// tb_wrr_arb: directed scoreboard bench for wrr_arb. The stimulus process
// drives inputs on the falling edge and queues the grant expected after the
// next rising edge; a monitor pops and compares shortly after each rising edge.
module tb_wrr_arb;

   localparam int QW = 3;

   typedef struct {
      logic [3:0] gnt;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t exp_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;
`ifdef ARB_LOCK_EN
   logic lock_next = 1'b0;
`endif

   wrr_arb_if #(.QW(QW)) bus();

   wrr_arb #(.QW(QW), .NREQ(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   function automatic logic [1:0] encode(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic checkOutput(input exp_t e);
      logic [1:0] eid;
      logic       ebusy;
      eid   = encode(e.gnt);
      ebusy = |e.gnt;
      tests_run++;
      if (bus.gnt !== e.gnt || bus.gnt_id !== eid || bus.busy !== ebusy) begin
         tests_failed++;
         $display("[TB] FAIL %s: got gnt=%b gnt_id=%0d busy=%b, expected gnt=%b gnt_id=%0d busy=%b",
                  e.tag, bus.gnt, bus.gnt_id, bus.busy, e.gnt, eid, ebusy);
      end
   endtask

   task automatic applyStimulus(input logic r_rst, input logic [3:0] r_req,
                                input logic we, input logic [1:0] idx,
                                input logic [QW-1:0] q, input logic [3:0] exp_gnt,
                                input string tag);
      exp_t e;
      @(negedge clk);
      rst         = r_rst;
      bus.req     = r_req;
      bus.cfg_we  = we;
      bus.cfg_idx = idx;
      bus.cfg_q   = q;
`ifdef ARB_LOCK_EN
      bus.lock    = lock_next;
`endif
      e.gnt = exp_gnt;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] r_req, input logic [3:0] exp_gnt, input string tag);
      applyStimulus(1'b0, r_req, 1'b0, 2'd0, '0, exp_gnt, tag);
   endtask

   task automatic hold(input logic [3:0] r_req, input logic [3:0] exp_gnt, input int n,
                       input string tag);
      for (int k = 0; k < n; k++) drive(r_req, exp_gnt, tag);
   endtask

   task automatic doReset(input string tag);
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, '0, 4'b0000, tag);
   endtask

   // Monitor: compare one queued expectation per rising edge, 1 time unit late.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   // Directed stimulus with hand-derived grant sequences.
   initial begin
      bus.req     = 4'b0000;
      bus.cfg_we  = 1'b0;
      bus.cfg_idx = 2'd0;
      bus.cfg_q   = '0;
`ifdef ARB_LOCK_EN
      bus.lock    = 1'b0;
`endif

      // Reset holds everything idle even with all requests high.
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, '0, 4'b0000, "reset_ignores_req");
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, '0, 4'b0000, "reset_ignores_req");

      // Lone requester 0 keeps the grant with no bubble across re-grants.
      hold(4'b0001, 4'b0001, 12, "single_req");
      drive(4'b0000, 4'b0000, "single_drop");

      // Full rotation with the default quantum of 3 (4 cycles each).
      doReset("reset_rotate");
      hold(4'b1111, 4'b0001, 4, "rotate_r0");
      hold(4'b1111, 4'b0010, 4, "rotate_r1");
      hold(4'b1111, 4'b0100, 4, "rotate_r2");
      hold(4'b1111, 4'b1000, 4, "rotate_r3");
      hold(4'b1111, 4'b0001, 4, "rotate_wrap");
      drive(4'b0000, 4'b0000, "rotate_drop");

      // Q[1]=0 and Q[2]=7: one cycle for 1, eight for 2.
      doReset("reset_weights");
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd1, 3'd0, 4'b0000, "cfg_q1");
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd2, 3'd7, 4'b0000, "cfg_q2");
      hold(4'b0110, 4'b0010, 1, "weight_q0");
      hold(4'b0110, 4'b0100, 8, "weight_q7");
      hold(4'b0110, 4'b0010, 1, "weight_q0_again");
      hold(4'b0110, 4'b0100, 8, "weight_q7_again");
      drive(4'b0000, 4'b0000, "weight_drop");

      // Requester 2 drops early with 0 pending: immediate handover.
      hold(4'b0100, 4'b0100, 2, "early_r2");
      hold(4'b0001, 4'b0001, 4, "early_handover");
      drive(4'b0000, 4'b0000, "early_idle");

      // Requester 2 drops early with nothing pending: back to idle.
      hold(4'b0100, 4'b0100, 2, "drop_r2");
      drive(4'b0000, 4'b0000, "drop_to_idle");

      // A late request from 1 waits for 0's quantum to expire.
      drive(4'b0001, 4'b0001, "late_r0");
      hold(4'b0011, 4'b0001, 3, "late_r0_keeps");
      drive(4'b0011, 4'b0010, "late_r1");
      drive(4'b0011, 4'b0001, "late_back_r0");
      drive(4'b0000, 4'b0000, "late_drop");

      // Rewriting Q[0] mid-grant only takes effect on 0's next grant.
      doReset("reset_cfg_mid");
      drive(4'b0011, 4'b0001, "cfgmid_r0");
      applyStimulus(1'b0, 4'b0011, 1'b1, 2'd0, 3'd1, 4'b0001, "cfgmid_write");
      hold(4'b0011, 4'b0001, 2, "cfgmid_old_q");
      hold(4'b0011, 4'b0010, 4, "cfgmid_r1");
      hold(4'b0011, 4'b0001, 2, "cfgmid_new_q");
      drive(4'b0000, 4'b0000, "cfgmid_drop");

      // Config write on the same edge as a new grant: old quantum (3) used.
      applyStimulus(1'b0, 4'b0010, 1'b1, 2'd1, 3'd0, 4'b0010, "cfgsame_grant");
      hold(4'b0011, 4'b0010, 3, "cfgsame_old_q");
      hold(4'b0011, 4'b0001, 2, "cfgsame_r0");
      drive(4'b0011, 4'b0010, "cfgsame_new_q");
      hold(4'b0011, 4'b0001, 2, "cfgsame_r0_again");
      drive(4'b0000, 4'b0000, "cfgsame_drop");

      // Reset mid-grant, then a grant on the first edge after release.
      hold(4'b0100, 4'b0100, 2, "rstmid_r2");
      applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, '0, 4'b0000, "rstmid_active");
      applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, '0, 4'b0000, "rstmid_active");
      drive(4'b1000, 4'b1000, "rstmid_first_grant");
      hold(4'b1000, 4'b1000, 3, "rstmid_r3");
      drive(4'b0000, 4'b0000, "rstmid_drop");

`ifdef ARB_LOCK_EN
      // Lock stretches requester 0 past its quantum; expiry on lock release.
      doReset("reset_lock");
      lock_next = 1'b1;
      hold(4'b0011, 4'b0001, 10, "lock_hold");
      lock_next = 1'b0;
      drive(4'b0011, 4'b0010, "lock_release");
      drive(4'b0000, 4'b0000, "lock_drop");
`endif

      // Let the monitor drain the queue, bounded.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
